// File: rtl/hdmi_audio_sample_packer.sv
// Packs multichannel audio frames into HDMI Audio Sample Packet bodies (Layout 0 / Layout 1)
// and queues finished packets in a first-word fall-through FIFO with registered head outputs.
module hdmi_audio_sample_packer #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int CHANNELS        = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk_audio,
  input  logic                                  reset,
  input  logic                                  sample_valid,
  output logic                                  sample_ready,
  input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0]   sample_word,
  input  logic                                  flush,
  output logic                                  pkt_valid,
  input  logic                                  pkt_ready,
  output logic                                  pkt_layout,
  output logic [3:0]                            pkt_present,
  output logic [3:0]                            pkt_b_flag,
  output logic [191:0]                          pkt_sample,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fill
);

  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit LAYOUT1 = (CHANNELS != 2);
  localparam int NPAIR = CHANNELS / 2;
  localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
  localparam logic [3:0] L1_PRESENT = 4'((1 << NPAIR) - 1);

  function automatic logic [23:0] justify(input logic [AUDIO_BIT_WIDTH-1:0] w);
    logic [23:0] r;
    r = 24'd0;
    r[23 -: AUDIO_BIT_WIDTH] = w;
    return r;
  endfunction

  logic [1:0]   slot_q, slot_d;
  logic [7:0]   fc_q, fc_d;
  logic         flush_pend_q, flush_pend_d;
  logic [191:0] asm_sample_q, asm_sample_d;
  logic [3:0]   asm_b_q, asm_b_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic         pkt_valid_q, pkt_valid_d;
  logic [3:0]   pkt_present_q, pkt_present_d;
  logic [3:0]   pkt_b_flag_q, pkt_b_flag_d;
  logic [191:0] pkt_sample_q, pkt_sample_d;

  logic [191:0] mem_sample_q [FIFO_DEPTH];
  logic [3:0]   mem_present_q [FIFO_DEPTH];
  logic [3:0]   mem_b_q [FIFO_DEPTH];

  logic         accept_s, pop_s, space_s, push_s, frame_b_s, flush_req_s;
  logic [191:0] frame_s, asm_next_s, push_sample_s;
  logic [3:0]   asm_b_next_s, push_present_s, push_b_s;
  logic [2:0]   slot_after_s;

  // Frame intake, subpacket assembly and the single push decision for this edge.
  always_comb begin
    accept_s    = sample_valid && (fill_q != FULL);
    pop_s       = pkt_valid_q && pkt_ready;
    space_s     = (fill_q != FULL) || pop_s;
    frame_b_s   = (fc_q == 8'd0);
    flush_req_s = flush || flush_pend_q;

    if (accept_s) begin
      fc_d = (fc_q == 8'd191) ? 8'd0 : fc_q + 8'd1;
    end else begin
      fc_d = fc_q;
    end

    frame_s = 192'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_s[c*24 +: 24] = justify(sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
    end

    asm_next_s   = asm_sample_q;
    asm_b_next_s = asm_b_q;
    for (int s = 0; s < 4; s++) begin
      asm_next_s[s*48 +: 48] = (accept_s && (2'(s) == slot_q)) ? frame_s[47:0] : asm_sample_q[s*48 +: 48];
      asm_b_next_s[s]        = (accept_s && (2'(s) == slot_q)) ? frame_b_s : asm_b_q[s];
    end
    slot_after_s = accept_s ? ({1'b0, slot_q} + 3'd1) : {1'b0, slot_q};

    push_s         = 1'b0;
    push_sample_s  = asm_next_s;
    push_b_s       = asm_b_next_s;
    push_present_s = 4'((5'd1 << slot_after_s) - 5'd1);
    slot_d         = slot_after_s[1:0];
    asm_sample_d   = asm_next_s;
    asm_b_d        = asm_b_next_s;
    flush_pend_d   = 1'b0;

    if (LAYOUT1) begin
      push_s         = accept_s;
      push_sample_s  = frame_s;
      push_present_s = L1_PRESENT;
      push_b_s       = {4{frame_b_s}} & L1_PRESENT;
      slot_d         = 2'd0;
      asm_sample_d   = 192'd0;
      asm_b_d        = 4'd0;
    end else if (slot_after_s == 3'd4) begin
      // A completing frame wins over any flush on the same edge.
      push_s       = 1'b1;
      slot_d       = 2'd0;
      asm_sample_d = 192'd0;
      asm_b_d      = 4'd0;
    end else if (flush_req_s && (slot_after_s != 3'd0)) begin
      if (space_s) begin
        push_s       = 1'b1;
        slot_d       = 2'd0;
        asm_sample_d = 192'd0;
        asm_b_d      = 4'd0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and the next registered head.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    pkt_valid_d = (fill_d != FW'(0));
    if (fill_d == FW'(0)) begin
      pkt_present_d = 4'd0;
      pkt_b_flag_d  = 4'd0;
      pkt_sample_d  = 192'd0;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      pkt_present_d = push_present_s;
      pkt_b_flag_d  = push_b_s;
      pkt_sample_d  = push_sample_s;
    end else begin
      pkt_present_d = mem_present_q[rd_ptr_d];
      pkt_b_flag_d  = mem_b_q[rd_ptr_d];
      pkt_sample_d  = mem_sample_q[rd_ptr_d];
    end
  end

  // Packet storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_audio) begin
    if (push_s) begin
      mem_sample_q[wr_ptr_q]  <= push_sample_s;
      mem_present_q[wr_ptr_q] <= push_present_s;
      mem_b_q[wr_ptr_q]       <= push_b_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      slot_q        <= 2'd0;
      fc_q          <= 8'd0;
      flush_pend_q  <= 1'b0;
      asm_sample_q  <= 192'd0;
      asm_b_q       <= 4'd0;
      wr_ptr_q      <= AW'(0);
      rd_ptr_q      <= AW'(0);
      fill_q        <= FW'(0);
      pkt_valid_q   <= 1'b0;
      pkt_present_q <= 4'd0;
      pkt_b_flag_q  <= 4'd0;
      pkt_sample_q  <= 192'd0;
    end else begin
      slot_q        <= slot_d;
      fc_q          <= fc_d;
      flush_pend_q  <= flush_pend_d;
      asm_sample_q  <= asm_sample_d;
      asm_b_q       <= asm_b_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_present_q <= pkt_present_d;
      pkt_b_flag_q  <= pkt_b_flag_d;
      pkt_sample_q  <= pkt_sample_d;
    end
  end

  assign sample_ready = (fill_q != FULL);
  assign fill         = fill_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_layout   = 1'(LAYOUT1);
  assign pkt_present  = pkt_present_q;
  assign pkt_b_flag   = pkt_b_flag_q;
  assign pkt_sample   = pkt_sample_q;

endmodule

// File: tb/tb_hdmi_audio_sample_packer.sv
// Bench for hdmi_audio_sample_packer: three configurations checked against a queue-based packet model,
// a directed Layout 0 vector table, and hand-written corner-case sequences.
module tb_hdmi_audio_sample_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] sv, fl, pr;
  logic [2:0][191:0] sw;
  wire  [2:0] sr, pv, lay;
  wire  [2:0][3:0] pp, pb;
  wire  [2:0][191:0] ps;
  wire  [2:0][2:0] fo;
  assign fo[2][2] = 1'b0;

  hdmi_audio_sample_packer #(.AUDIO_BIT_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4)) dut0 (
    .clk_audio(clk), .reset(rst), .sample_valid(sv[0]), .sample_ready(sr[0]),
    .sample_word(sw[0][31:0]), .flush(fl[0]), .pkt_valid(pv[0]), .pkt_ready(pr[0]),
    .pkt_layout(lay[0]), .pkt_present(pp[0]), .pkt_b_flag(pb[0]), .pkt_sample(ps[0]), .fill(fo[0]));
  hdmi_audio_sample_packer #(.AUDIO_BIT_WIDTH(20), .CHANNELS(4), .FIFO_DEPTH(4)) dut1 (
    .clk_audio(clk), .reset(rst), .sample_valid(sv[1]), .sample_ready(sr[1]),
    .sample_word(sw[1][79:0]), .flush(fl[1]), .pkt_valid(pv[1]), .pkt_ready(pr[1]),
    .pkt_layout(lay[1]), .pkt_present(pp[1]), .pkt_b_flag(pb[1]), .pkt_sample(ps[1]), .fill(fo[1]));
  hdmi_audio_sample_packer #(.AUDIO_BIT_WIDTH(24), .CHANNELS(6), .FIFO_DEPTH(2)) dut2 (
    .clk_audio(clk), .reset(rst), .sample_valid(sv[2]), .sample_ready(sr[2]),
    .sample_word(sw[2][143:0]), .flush(fl[2]), .pkt_valid(pv[2]), .pkt_ready(pr[2]),
    .pkt_layout(lay[2]), .pkt_present(pp[2]), .pkt_b_flag(pb[2]), .pkt_sample(ps[2]), .fill(fo[2][1:0]));

  typedef struct packed {
    logic [3:0]   pres;
    logic [3:0]   b;
    logic [191:0] smp;
  } pkt_t;

  typedef struct {
    bit sv; logic [15:0] l; logic [15:0] r; bit fl; bit pr;
    bit ev; int ef; logic [3:0] ep; logic [3:0] eb; logic [23:0] es0;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  pkt_t mq[$];
  logic [47:0] asm_q[$];
  bit asm_bq[$];
  int nfr = 0;
  bit fpend = 1'b0;

  function automatic int ch(int d);
    case (d)
      0: return 2;
      1: return 4;
      default: return 6;
    endcase
  endfunction
  function automatic int wd(int d);
    case (d)
      0: return 16;
      1: return 20;
      default: return 24;
    endcase
  endfunction
  function automatic int dp(int d);
    case (d)
      0: return 4;
      1: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [23:0] jus(int d, int c);
    logic [191:0] t;
    logic [31:0] v;
    t = sw[d] >> (c * wd(d));
    v = t[31:0] & ((32'd1 << wd(d)) - 32'd1);
    v = v << (24 - wd(d));
    return v[23:0];
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete(); asm_q.delete(); asm_bq.delete();
    nfr = 0; fpend = 1'b0;
  endtask

  task automatic emit_l0();
    pkt_t p;
    p.pres = 4'((1 << asm_q.size()) - 1);
    p.b = 4'd0;
    p.smp = 192'd0;
    for (int i = 0; i < asm_q.size(); i++) begin
      p.smp[i*48 +: 48] = asm_q[i];
      p.b[i] = asm_bq[i];
    end
    mq.push_back(p);
    asm_q.delete(); asm_bq.delete();
  endtask

  // One clock edge for the DUT under test: advance the model, clock, then compare.
  task automatic step();
    int d;
    bit full, pop, acc, space, bf;
    pkt_t p;
    d = cur;
    full  = (mq.size() == dp(d));
    pop   = (mq.size() != 0) && pr[d];
    acc   = sv[d] && !full;
    space = !full || pop;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      bf = ((nfr % 192) == 0);
      nfr++;
      if (ch(d) == 2) begin
        asm_q.push_back({jus(d, 1), jus(d, 0)});
        asm_bq.push_back(bf);
        if (asm_q.size() == 4) emit_l0();
      end else begin
        p.pres = 4'((1 << (ch(d) / 2)) - 1);
        p.b = bf ? p.pres : 4'd0;
        p.smp = 192'd0;
        for (int c = 0; c < ch(d); c++) p.smp[c*24 +: 24] = jus(d, c);
        mq.push_back(p);
      end
    end
    if (ch(d) == 2 && (fl[d] || fpend)) begin
      if (asm_q.size() == 0) fpend = 1'b0;
      else if (space) begin emit_l0(); fpend = 1'b0; end
      else fpend = 1'b1;
    end
    @(posedge clk); #1;
    chk("sample_ready", 192'(sr[d]), 192'(mq.size() != dp(d)));
    chk("pkt_valid", 192'(pv[d]), 192'(mq.size() != 0));
    chk("fill", 192'(fo[d]), 192'(mq.size()));
    chk("pkt_layout", 192'(lay[d]), 192'(ch(d) != 2));
    if (mq.size() != 0) begin
      chk("head_present", 192'(pp[d]), 192'(mq[0].pres));
      chk("head_b_flag", 192'(pb[d]), 192'(mq[0].b));
      chk("head_sample", ps[d], mq[0].smp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic idle_inputs();
    sv = 3'b000; fl = 3'b000; pr = 3'b000;
  endtask

  task automatic rand_word(input int d);
    for (int k = 0; k < 6; k++) sw[d][k*32 +: 32] = $urandom;
  endtask

  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int npk, got, nxt;
    logic [23:0] popped[$];
    rst = 1'b1;
    idle_inputs();
    sw = '0;
    tbl[0]  = '{1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[1]  = '{1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[2]  = '{1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[3]  = '{1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 1, 4'hF, 4'h1, 24'h123400};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'hF, 4'h1, 24'h123400};
    tbl[5]  = '{1'b1, 16'h0A01, 16'h0B01, 1'b0, 1'b1, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[6]  = '{1'b1, 16'h0A02, 16'h0B02, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[7]  = '{1'b1, 16'h0A03, 16'h0B03, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 4'h7, 4'h0, 24'h0A0100};
    tbl[9]  = '{1'b1, 16'h0A04, 16'h0B04, 1'b1, 1'b1, 1'b1, 1, 4'h1, 4'h0, 24'h0A0400};
    tbl[10] = '{1'b1, 16'h0A05, 16'h0B05, 1'b0, 1'b1, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[11] = '{1'b1, 16'h0A06, 16'h0B06, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[12] = '{1'b1, 16'h0A07, 16'h0B07, 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 24'h0};
    tbl[13] = '{1'b1, 16'h0A08, 16'h0B08, 1'b1, 1'b0, 1'b1, 1, 4'hF, 4'h0, 24'h0A0500};
    tbl[14] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'hF, 4'h0, 24'h0A0500};
    tbl[15] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 4'h0, 4'h0, 24'h0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    for (int d = 0; d < 3; d++) begin
      chk("rst_pkt_valid", 192'(pv[d]), 192'(0));
      chk("rst_fill", 192'(fo[d]), 192'(0));
      chk("rst_sample_ready", 192'(sr[d]), 192'(1));
      chk("rst_present_b", 192'({pp[d], pb[d]}), 192'(0));
      chk("rst_sample", ps[d], 192'd0);
      chk("rst_layout", 192'(lay[d]), 192'(d != 0));
    end

    // Directed Layout 0 table: basic packet, partial flush, flush on the completing frame.
    cur = 0;
    for (int i = 0; i < 16; i++) begin
      sv[0] = tbl[i].sv; fl[0] = tbl[i].fl; pr[0] = tbl[i].pr;
      sw[0] = '0; sw[0][15:0] = tbl[i].l; sw[0][31:16] = tbl[i].r;
      step();
      chk("tbl_ready", 192'(sr[0]), 192'(1));
      chk("tbl_valid", 192'(pv[0]), 192'(tbl[i].ev));
      chk("tbl_fill", 192'(fo[0]), 192'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk("tbl_present", 192'(pp[0]), 192'(tbl[i].ep));
        chk("tbl_b_flag", 192'(pb[0]), 192'(tbl[i].eb));
        chk("tbl_sample0", 192'(ps[0][23:0]), 192'(tbl[i].es0));
        if (tbl[i].ep != 4'hF) chk("tbl_sub3_zero", 192'(ps[0][191:144]), 192'(0));
      end
    end
    idle_inputs();

    // Frame counter wrap: 196 frames, B set only on packets 0 and 48.
    do_reset();
    cur = 0; npk = 0;
    pr[0] = 1'b1;
    for (int i = 0; i < 197; i++) begin
      sv[0] = (i < 196);
      rand_word(0);
      step();
      if (pv[0]) begin
        chk("wrap_b_flag", 192'(pb[0]), 192'((npk == 0 || npk == 48) ? 4'b0001 : 4'b0000));
        npk++;
      end
    end
    chk("wrap_packets", 192'(npk), 192'(49));
    idle_inputs();

    // Reset mid-operation with fill 3 and slot 2; accept and flush on the reset edge are discarded.
    do_reset();
    cur = 0;
    for (int i = 0; i < 14; i++) begin sv[0] = 1'b1; rand_word(0); step(); end
    chk("pre_rst_fill", 192'(fo[0]), 192'(3));
    sv[0] = 1'b1; fl[0] = 1'b1;
    do_reset();
    chk("mid_rst_valid", 192'(pv[0]), 192'(0));
    chk("mid_rst_fill", 192'(fo[0]), 192'(0));
    fl[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin sv[0] = 1'b1; rand_word(0); step(); end
    chk("post_rst_b", 192'(pb[0]), 192'(4'b0001));
    chk("post_rst_present", 192'(pp[0]), 192'(4'b1111));
    idle_inputs();

    // Backpressure on the 4-channel instance: 6 frames offered into a 4-deep FIFO.
    do_reset();
    cur = 1;
    for (int i = 0; i < 4; i++) begin
      sv[1] = 1'b1; rand_word(1); sw[1][19:0] = 20'hA0000 + 20'(i);
      chk("bp_ready_before", 192'(sr[1]), 192'(1));
      step();
    end
    chk("bp_ready_dropped", 192'(sr[1]), 192'(0));
    chk("bp_fill_full", 192'(fo[1]), 192'(4));
    sw[1][19:0] = 20'hA0004;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_head_held", 192'(ps[1][23:0]), 192'(24'hA00000));
    end
    pr[1] = 1'b1; nxt = 4; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      sv[1] = (nxt < 6);
      sw[1][19:0] = 20'hA0000 + 20'(nxt);
      if (pv[1]) begin popped.push_back(ps[1][23:0]); got++; end
      if (sv[1] && mq.size() != 4) nxt++;
      step();
    end
    chk("bp_drained", 192'(got), 192'(6));
    for (int i = 0; i < popped.size(); i++) chk("bp_order", 192'(popped[i]), 192'(24'hA00000 + 24'(i * 16)));
    idle_inputs();

    // Layout 1 with 6 channels at 24 bits, then back-to-back frames.
    do_reset();
    cur = 2;
    sv[2] = 1'b1;
    sw[2] = '0;
    for (int c = 0; c < 6; c++) sw[2][c*24 +: 24] = 24'hC00000 + 24'(c * 24'h111);
    step();
    chk("l1_present", 192'(pp[2]), 192'(4'b0111));
    chk("l1_b_flag", 192'(pb[2]), 192'(4'b0111));
    chk("l1_layout", 192'(lay[2]), 192'(1));
    chk("l1_sub3_zero", 192'(ps[2][191:144]), 192'(0));
    chk("l1_ch0", 192'(ps[2][23:0]), 192'(24'hC00000));
    chk("l1_ch5", 192'(ps[2][143:120]), 192'(24'hC00555));
    pr[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_word(2); fl[2] = (i % 5 == 0);
      step();
      chk("b2b_fill", 192'(fo[2]), 192'(1));
    end
    idle_inputs();

    // Randomized traffic on every configuration against the packet model.
    for (int d = 0; d < 3; d++) begin
      do_reset();
      cur = d;
      for (int i = 0; i < 250; i++) begin
        sv[d] = ($urandom % 4) != 0;
        fl[d] = ($urandom % 8) == 0;
        pr[d] = (i < 125) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
        rand_word(d);
        step();
      end
      idle_inputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_audio_sample_packer.md
# hdmi_audio_sample_packer

Multichannel successor to the fixed stereo sample buffering inside the HDMI packet picker. It runs entirely in the `clk_audio` domain and accepts one audio frame per handshake, carrying `CHANNELS` channels. Frames are assembled into complete HDMI Audio Sample Packet bodies, using Layout 0 for 2 channels and Layout 1 for 4–8 channels, with per-subpacket IEC 60958 block-start (B) flags. Finished packets are queued in a `FIFO_DEPTH`-entry packet FIFO, which feeds the pixel-domain CDC and picker through a valid/ready interface.

## Interface
- `AUDIO_BIT_WIDTH`, 16: sample width; legal range 16..24.
- `CHANNELS`, 2: channel count; legal values 2, 4, 6, 8. A value of 2 selects Layout 0; any other value selects Layout 1.
- `FIFO_DEPTH`, 4: packet FIFO entries; a power of two, at least 2.
- `clk_audio`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  a frame is offered on `sample_word`.
- `sample_ready`  out  1  the block can accept a frame.
- `sample_word`  in  CHANNELS*AUDIO_BIT_WIDTH  channel c occupies bits [c*W +: W].
- `flush`  in  1  single-cycle pulse; emits a partially filled Layout 0 packet.
- `pkt_valid`  out  1  the FIFO head is valid.
- `pkt_ready`  in  1  the consumer pops the head.
- `pkt_layout`  out  1  0 = Layout 0, 1 = Layout 1.
- `pkt_present`  out  4  `sample_present` bit per subpacket.
- `pkt_b_flag`  out  4  B bit per subpacket.
- `pkt_sample`  out  192  subpacket s, channel k is at bits [(2s+k)*24 +: 24], left-justified.
- `fill`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- **Accept.** A frame is accepted on `sample_valid && sample_ready`. `sample_ready = (fill != FIFO_DEPTH)`, driven from a registered count. No frame is ever dropped.
- **Justification.** Each channel word is stored as `{word, (24-W)'b0}`, i.e. left-justified in 24 bits.
- **Frame counter.** `fc` runs 0..191 and increments once per accepted frame, wrapping 191 -> 0. A subpacket's B flag is 1 when the frame it holds had `fc == 0`.
- **Layout 0 (CHANNELS = 2).**
  - An assembly register collects frames into subpackets 0..3 in order, tracked by slot counter `slot` (0..3).
  - On the 4th frame, the packet is pushed on the same edge with `present = 4'b1111`, and `slot` returns to 0.
- **Layout 1 (CHANNELS > 2).**
  - Every accepted frame is pushed as one packet.
  - Channel pair p goes to subpacket p.
  - `present` has bits [CHANNELS/2-1:0] set; unused subpackets are zero.
  - All present subpackets carry the same B flag.
- **Flush (Layout 0 only).**
  - If `slot > 0` after the current edge's accept, a packet is pushed with `present` bits [slot-1:0] set and unfilled subpackets zeroed. `slot` then returns to 0.
  - If the accept on the same edge completes a packet, only that normal push occurs.
  - Flush is ignored when `slot == 0` and in Layout 1.
  - Flush while `fill == FIFO_DEPTH` is deferred until the first cycle with space, and is held pending internally.
  - Flush never alters `fc`.
- **FIFO.** First-word fall-through: the head is presented registered. A pop happens on `pkt_valid && pkt_ready`. A push and a pop on the same edge leave `fill` unchanged, and a push is allowed at full if a pop occurs on the same edge. The combinational `sample_ready` is nevertheless computed from the registered `fill` only.
- **Reset.** Clears the FIFO, `slot`, `fc`, and any pending flush. Reset wins over a simultaneous accept or flush, and data in flight is discarded.

## Timing
- **Reset values:** `pkt_valid` = 0, `fill` = 0, `sample_ready` = 1 (from the first cycle after reset deasserts), `pkt_present` = 0, `pkt_b_flag` = 0, `pkt_sample` = 0, `pkt_layout` = the constant for the configuration.
- **Latency:** `pkt_valid` rises 1 cycle after the edge that pushes into an empty FIFO, and the head updates 1 cycle after a pop.
- **Back-to-back:** a Layout 1 packet can be pushed every cycle. Sustained throughput is 1 frame/cycle while `pkt_ready` stays high.
- **Output stability:** while `pkt_valid && !pkt_ready`, all `pkt_*` outputs hold stable.

## Test plan
- **Layout 0 basic:** W=16, C=2, 4 frames with L=0x1234, R=0x5678 each -> one packet with present 1111, `pkt_sample[23:0]` = 0x123400, B = 0001 (fc 0..3).
- **Layout 1:** C=6, W=24, one frame -> packet with present 0111, subpacket 3 all zero, and `pkt_layout` = 1.
- **Frame wrap:** C=2, 196 frames -> 49 packets; packet 48 carries B = 0001 (frames 192..195 wrap to fc 0..3), and every other packet carries B = 0000 except packet 0.
- **Backpressure:** FIFO_DEPTH=4, C=4, `pkt_ready` = 0, 6 frames offered -> `sample_ready` drops after the 4th, `fill` = 4, and the head is held. Releasing `pkt_ready` drains all 6 in order.
- **Flush:** C=2, 3 frames then `flush` -> present 0111 with subpacket 3 zero. A `flush` on the edge of the 4th frame yields exactly one full packet.
- **Reset mid-operation:** reset with `fill` = 3, `slot` = 2 -> the next cycle has `pkt_valid` = 0 and `fill` = 0. The next 4 frames form a packet with B = 0001.
